apb_master: RTL and testbench

- Single-transfer APB initiator. Accepts one read or write command at a time on a valid/ready request port and drives a complete APB SETUP/ACCESS sequence.
- Returns read data and error status on a valid/ready response port.
- Sits between the test/host-side sequencer and the I2S transceiver's APB register slave; it is the bus-side counterpart of that slave.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_master.sv | 109 ++++++++++
 tb/tb_apb_master.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM states, command record and register offsets for the APB initiator
package apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apb_cmd_t;

    localparam logic [31:0] REG_CTRL   = 32'h0;
    localparam logic [31:0] REG_TXDATA = 32'h4;
    localparam logic [31:0] REG_RXDATA = 32'h8;

endpackage

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB initiator bridging a valid/ready command port to SETUP/ACCESS transfers
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] paddr,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    apb_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic [ADDR_W-1:0] paddr_q;
    logic              pwrite_q;
    logic [DATA_W-1:0] pwdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q, tmo_q;
    logic              accept, timeout_hit;

    assign accept      = (state_q == IDLE) && cmd_valid;
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !pready && (cnt_q == CNT_LAST);

    // state register; async reset drops psel/penable immediately and discards any pending response
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // next state: a ready slave on the abort cycle completes normally since pready is tested first
    always_comb begin
        state_d = state_q == IDLE   ? (cmd_valid ? SETUP : IDLE) :
                  state_q == SETUP  ? ACCESS :
                  state_q == ACCESS ? ((pready || timeout_hit) ? RESP : ACCESS) :
                                      (rsp_ready ? IDLE : RESP);
    end

    // command capture, saturating wait counter and response capture
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pwdata_q <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            if (accept) begin
                paddr_q  <= cmd_addr;
                pwrite_q <= cmd_write;
                pwdata_q <= cmd_wdata;
                cnt_q    <= '0;
            end
            if (state_q == ACCESS) begin
                if (pready) begin
                    rdata_q <= pwrite_q ? '0 : prdata;
                    err_q   <= pslverr;
                    tmo_q   <= 1'b0;
                end else begin
                    cnt_q <= (&cnt_q) ? cnt_q : cnt_q + CW'(1);
                    if (timeout_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        tmo_q   <= 1'b1;
                    end
                end
            end
        end
    end

    // outputs decoded from the current state
    always_comb begin
        cmd_ready = (state_q == IDLE) && !preset;
        psel      = (state_q == SETUP) || (state_q == ACCESS);
        penable   = state_q == ACCESS;
        rsp_valid = state_q == RESP;
    end

    assign paddr       = paddr_q;
    assign pwrite      = pwrite_q;
    assign pwdata      = pwdata_q;
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven transfers plus back-pressure and mid-transfer reset sequences
module tb_apb_master;
    import apb_pkg::*;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready, pslverr;

    int vecs = 0;
    int errs = 0;

    apb_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] prdata;
        logic        slverr;
        int          waits;
        logic [31:0] e_rdata;
        logic        e_err;
        logic        e_tmo;
        int          e_acc;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // starts and ends just after a falling edge
    task automatic xfer(input vec_t v);
        int acc = 0;
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        rsp_ready = 1'b1; pready = 1'b0; prdata = v.prdata; pslverr = v.slverr;
        #1 chk("cmd_ready_idle", cmd_ready, 1);
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, v.addr);
        chk("setup_pwrite", pwrite, v.wr);
        if (v.wr) chk("setup_pwdata", pwdata, v.wdata);
        while (acc < 50) begin
            @(negedge pclk);
            if (!penable) break;
            chk("access_psel", psel, 1);
            chk("access_paddr", paddr, v.addr);
            chk("access_pwrite", pwrite, v.wr);
            pready = (acc >= v.waits);
            acc++;
        end
        pready = 1'b0;
        chk("access_cycles", acc, v.e_acc);
        chk("resp_valid", rsp_valid, 1);
        chk("resp_psel", psel, 0);
        chk("resp_rdata", rsp_rdata, v.e_rdata);
        chk("resp_err", rsp_err, v.e_err);
        chk("resp_timeout", rsp_timeout, v.e_tmo);
        @(negedge pclk);
        chk("after_rsp_valid", rsp_valid, 0);
        chk("after_cmd_ready", cmd_ready, 1);
    endtask

    initial begin
        tbl[0] = '{1'b1, REG_TXDATA, 32'hA5A5_0001, 32'hFFFF_FFFF, 1'b0, 0,  32'h0,         1'b0, 1'b0, 1};
        tbl[1] = '{1'b0, REG_RXDATA, 32'h0,         32'h1234_5678, 1'b0, 0,  32'h1234_5678, 1'b0, 1'b0, 1};
        tbl[2] = '{1'b0, REG_CTRL,   32'h0,         32'hDEAD_BEEF, 1'b1, 3,  32'hDEAD_BEEF, 1'b1, 1'b0, 4};
        tbl[3] = '{1'b1, 32'h10,     32'h0000_00FF, 32'h1111_1111, 1'b1, 3,  32'h0,         1'b1, 1'b0, 4};
        tbl[4] = '{1'b0, 32'h14,     32'h0,         32'h0000_FFFF, 1'b1, 99, 32'h0,         1'b1, 1'b1, 4};
        tbl[5] = '{1'b0, 32'h0C,     32'h0,         32'h0BAD_F00D, 1'b0, 2,  32'h0BAD_F00D, 1'b0, 1'b0, 3};

        preset = 1'b1; cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        rsp_ready = 1'b0; prdata = 32'h0; pready = 1'b0; pslverr = 1'b0;
        @(negedge pclk); @(negedge pclk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        preset = 1'b0; cmd_valid = 1'b0;
        @(negedge pclk);

        for (int i = 0; i < 6; i++) xfer(tbl[i]);

        // response back-pressure with a second command held at the port
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_RXDATA; rsp_ready = 1'b0;
        @(negedge pclk);
        cmd_write = 1'b1; cmd_addr = REG_CTRL; cmd_wdata = 32'h77;
        chk("bp_setup_cmd_ready", cmd_ready, 0);
        @(negedge pclk);
        chk("bp_access_penable", penable, 1);
        pready = 1'b1; prdata = 32'h55AA_33CC; pslverr = 1'b0;
        @(negedge pclk);
        pready = 1'b0; prdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h55AA_33CC);
            chk("bp_cmd_ready", cmd_ready, 0);
            chk("bp_psel", psel, 0);
            @(negedge pclk);
        end
        rsp_ready = 1'b1;
        chk("bp_rsp_still_valid", rsp_valid, 1);
        @(negedge pclk);
        chk("bp_idle_cmd_ready", cmd_ready, 1);
        chk("bp_idle_psel", psel, 0);
        @(negedge pclk);
        cmd_valid = 1'b0;
        chk("bp_next_psel", psel, 1);
        chk("bp_next_paddr", paddr, REG_CTRL);
        chk("bp_next_pwrite", pwrite, 1);
        chk("bp_next_pwdata", pwdata, 32'h77);
        @(negedge pclk);
        pready = 1'b1;
        @(negedge pclk);
        pready = 1'b0;
        chk("bp_next_rsp_valid", rsp_valid, 1);
        chk("bp_next_rsp_rdata", rsp_rdata, 0);
        @(negedge pclk);

        // reset while the slave stalls in ACCESS
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = REG_RXDATA; pready = 1'b0;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        chk("ra_penable", penable, 1);
        @(negedge pclk);
        #2 preset = 1'b1;
        #1 chk("ra_psel_async", psel, 0);
        chk("ra_penable_async", penable, 0);
        @(negedge pclk);
        preset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            chk("ra_no_rsp", rsp_valid, 0);
            chk("ra_no_psel", psel, 0);
        end
        xfer('{1'b0, REG_CTRL, 32'h0, 32'hC0FF_EE00, 1'b0, 0, 32'hC0FF_EE00, 1'b0, 1'b0, 1});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
